// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared types and constants for the RTC register-burst logic.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_CMD_WAIT  = 3'd2,
        ST_XFER      = 3'd3,
        ST_XFER_WAIT = 3'd4,
        ST_NEXT      = 3'd5,
        ST_FINISH    = 3'd6,
        ST_ABORT     = 3'd7
    } rtc_state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [7:0] DEF_BASE_ADDR = 8'h21;
    localparam logic [7:0] DEF_CMD_ADDR  = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/rtc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_wait_timer
// Description : Down-counter bounding how long a bus transaction may take.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_wait_timer #(
    parameter int TIMEOUT = 255,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Preset to TIMEOUT-1 so a wait that sees the zero count has lasted TIMEOUT cycles.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = CNT_W'(TIMEOUT - 1);
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rtc_burst_ctrl
// Description : Read/write burst sequencer over consecutive RTC registers.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_burst_ctrl
    import rtc_pkg::*;
#(
    parameter int                NUM_REGS  = 9,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter bit                PRE_CMD   = 1'b1,
    parameter logic [ADDR_W-1:0] CMD_ADDR  = ADDR_W'(DEF_CMD_ADDR),
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              cycle_done,
    output logic              cyc_start,
    output logic              cyc_op,
    output logic              cmd_phase,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        sel_reg,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    rtc_state_e        state_q, state_d;
    logic              mode_q, mode_d;
    logic              err_q, err_d;
    logic [3:0]        index_q, index_d;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_tmr_expired;
    logic [ADDR_W-1:0] w_xfer_addr;

    assign w_xfer_addr = BASE_ADDR + ADDR_W'(index_q);

    rtc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= OP_RD;
            err_q   <= 1'b0;
            index_q <= 4'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        err_d     = err_q;
        index_d   = index_q;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;
        cyc_start = 1'b0;
        cyc_op    = OP_RD;
        cmd_phase = 1'b0;
        addr      = '0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    mode_d  = mode;
                    err_d   = 1'b0;
                    index_d = 4'd0;
                    state_d = PRE_CMD ? ST_CMD : ST_XFER;
                end
            end
            ST_CMD: begin
                cyc_start = 1'b1;
                cyc_op    = OP_WR;
                cmd_phase = 1'b1;
                addr      = CMD_ADDR;
                w_tmr_clr = 1'b1;
                state_d   = ST_CMD_WAIT;
            end
            ST_CMD_WAIT: begin
                cyc_op    = OP_WR;
                cmd_phase = 1'b1;
                addr      = CMD_ADDR;
                w_tmr_en  = 1'b1;
                // A completion arriving on the expiry cycle still counts as success.
                if (cycle_done) begin
                    state_d = ST_XFER;
                end else if (w_tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_XFER: begin
                cyc_start = 1'b1;
                cyc_op    = mode_q;
                addr      = w_xfer_addr;
                w_tmr_clr = 1'b1;
                state_d   = ST_XFER_WAIT;
            end
            ST_XFER_WAIT: begin
                cyc_op   = mode_q;
                addr     = w_xfer_addr;
                w_tmr_en = 1'b1;
                if (cycle_done) begin
                    state_d = ST_NEXT;
                end else if (w_tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_NEXT: begin
                cyc_op = mode_q;
                addr   = w_xfer_addr;
                if (index_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = ST_XFER;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                index_d = 4'd0;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                done    = 1'b1;
                index_d = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel_reg = index_q;
    assign err     = err_q;

endmodule
`default_nettype wire
